// File: rtl/mcalu_rs_pkg.sv
// Shared definitions for the multi-cycle ALU path: op codes, field widths
// and the reservation-station entry layout.
package mcalu_rs_pkg;

    localparam int unsigned OP_W    = 5;
    localparam int unsigned ROBID_W = 7;
    localparam int unsigned RD_W    = 6;
    localparam int unsigned DATA_W  = 32;

    // mcalu op codes, shared by decode, the RS and mcalu
    localparam logic [OP_W-1:0] MCALU_ADD   = 5'h00;
    localparam logic [OP_W-1:0] MCALU_SUB   = 5'h01;
    localparam logic [OP_W-1:0] MCALU_SLL   = 5'h02;
    localparam logic [OP_W-1:0] MCALU_SRL   = 5'h03;
    localparam logic [OP_W-1:0] MCALU_SRA   = 5'h04;
    localparam logic [OP_W-1:0] MCALU_MUL   = 5'h08;
    localparam logic [OP_W-1:0] MCALU_MULH  = 5'h09;
    localparam logic [OP_W-1:0] MCALU_MULHU = 5'h0a;
    localparam logic [OP_W-1:0] MCALU_DIV   = 5'h10;
    localparam logic [OP_W-1:0] MCALU_DIVU  = 5'h11;
    localparam logic [OP_W-1:0] MCALU_REM   = 5'h12;
    localparam logic [OP_W-1:0] MCALU_REMU  = 5'h13;

    // One reservation-station slot; a not-ready operand carries its producer tag in [ROBID_W-1:0]
    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [ROBID_W-1:0] robid;
        logic [RD_W-1:0]    rd;
        logic               op1_rdy;
        logic [DATA_W-1:0]  op1;
        logic               op2_rdy;
        logic [DATA_W-1:0]  op2;
    } rs_entry_t;

    // Tag compare of a pending operand against a broadcast robid
    function automatic logic tag_match(input logic [DATA_W-1:0] val,
                                       input logic [ROBID_W-1:0] tag);
        return val[ROBID_W-1:0] == tag;
    endfunction

endpackage

// File: rtl/mcalu_rs_operand_wakeup.sv
// Per-operand wakeup: captures the broadcast result when a pending operand's
// tag matches the writeback robid.
//   rdy, val              : current operand state (value or producer tag)
//   wb_valid/robid/result : writeback broadcast
//   rdy_nxt_c, val_nxt_c  : operand state after this cycle's broadcast
module rs_operand_wakeup
    import mcalu_rs_pkg::*;
(
    input  logic               rdy,
    input  logic [DATA_W-1:0]  val,
    input  logic               wb_valid,
    input  logic [ROBID_W-1:0] wb_robid,
    input  logic [DATA_W-1:0]  wb_result,
    output logic               rdy_nxt_c,
    output logic [DATA_W-1:0]  val_nxt_c
);

    logic hit_c;

    assign hit_c     = wb_valid & ~rdy & tag_match(val, wb_robid);
    assign rdy_nxt_c = rdy | hit_c;
    assign val_nxt_c = hit_c ? wb_result : val;

endmodule

// File: rtl/mcalu_rs.sv
// Reservation station in front of mcalu: a compacting age-ordered queue
// (slot 0 oldest) that captures pending operands from the writeback bus and
// issues the oldest fully-ready entry.
//   clk, rst (sync, active-low)
//   disp_*        : dispatch request and payload; rs_stall back-pressures it
//   wb_*          : writeback broadcast used for operand wakeup
//   exers_*       : issue to mcalu, combinational from registered state
//   mcalu_stall   : mcalu cannot accept the current issue
//   rob_flush     : drop every entry
module mcalu_rs
    import mcalu_rs_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               disp_valid,
    input  logic [OP_W-1:0]    disp_op,
    input  logic [ROBID_W-1:0] disp_robid,
    input  logic [RD_W-1:0]    disp_rd,
    input  logic               disp_op1_rdy,
    input  logic               disp_op2_rdy,
    input  logic [DATA_W-1:0]  disp_op1,
    input  logic [DATA_W-1:0]  disp_op2,
    output logic               rs_stall,
    input  logic               wb_valid,
    input  logic [ROBID_W-1:0] wb_robid,
    input  logic [DATA_W-1:0]  wb_result,
    output logic               exers_mcalu_issue,
    output logic [OP_W-1:0]    exers_mcalu_op,
    output logic [ROBID_W-1:0] exers_robid,
    output logic [RD_W-1:0]    exers_rd,
    output logic [DATA_W-1:0]  exers_op1,
    output logic [DATA_W-1:0]  exers_op2,
    input  logic               mcalu_stall,
    input  logic               rob_flush
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    rs_entry_t          ent_q   [DEPTH];
    rs_entry_t          ent_d   [DEPTH];
    rs_entry_t          woke_c  [DEPTH];
    rs_entry_t          shift_c [DEPTH];
    rs_entry_t          disp_c;
    logic [CNT_W-1:0]   count_q;
    logic [CNT_W-1:0]   count_d;
    logic [CNT_W-1:0]   wr_idx_c;
    logic [IDX_W-1:0]   sel_idx_c;
    logic               found_c;
    logic               issue_acc_c;
    logic               disp_acc_c;

    // Wakeup of stored operands; shift_c is the same view one slot higher, for compaction
    for (genvar g = 0; g < DEPTH; g++) begin : g_ent
        logic              op1_rdy_w;
        logic              op2_rdy_w;
        logic [DATA_W-1:0] op1_w;
        logic [DATA_W-1:0] op2_w;

        rs_operand_wakeup u_op1 (
            .rdy       (ent_q[g].op1_rdy),
            .val       (ent_q[g].op1),
            .wb_valid  (wb_valid),
            .wb_robid  (wb_robid),
            .wb_result (wb_result),
            .rdy_nxt_c (op1_rdy_w),
            .val_nxt_c (op1_w)
        );

        rs_operand_wakeup u_op2 (
            .rdy       (ent_q[g].op2_rdy),
            .val       (ent_q[g].op2),
            .wb_valid  (wb_valid),
            .wb_robid  (wb_robid),
            .wb_result (wb_result),
            .rdy_nxt_c (op2_rdy_w),
            .val_nxt_c (op2_w)
        );

        assign woke_c[g] = '{op: ent_q[g].op, robid: ent_q[g].robid, rd: ent_q[g].rd,
                             op1_rdy: op1_rdy_w, op1: op1_w,
                             op2_rdy: op2_rdy_w, op2: op2_w};

        // Top slot has nothing above it; its post-shift content is don't-care
        if (g < DEPTH - 1) begin : g_shift
            assign shift_c[g] = woke_c[g+1];
        end else begin : g_top
            assign shift_c[g] = woke_c[g];
        end
    end

    // Dispatch bypass: a broadcast in the dispatch cycle is captured on entry
    logic              d_op1_rdy_w;
    logic              d_op2_rdy_w;
    logic [DATA_W-1:0] d_op1_w;
    logic [DATA_W-1:0] d_op2_w;

    rs_operand_wakeup u_disp_op1 (
        .rdy       (disp_op1_rdy),
        .val       (disp_op1),
        .wb_valid  (wb_valid),
        .wb_robid  (wb_robid),
        .wb_result (wb_result),
        .rdy_nxt_c (d_op1_rdy_w),
        .val_nxt_c (d_op1_w)
    );

    rs_operand_wakeup u_disp_op2 (
        .rdy       (disp_op2_rdy),
        .val       (disp_op2),
        .wb_valid  (wb_valid),
        .wb_robid  (wb_robid),
        .wb_result (wb_result),
        .rdy_nxt_c (d_op2_rdy_w),
        .val_nxt_c (d_op2_w)
    );

    assign disp_c = '{op: disp_op, robid: disp_robid, rd: disp_rd,
                      op1_rdy: d_op1_rdy_w, op1: d_op1_w,
                      op2_rdy: d_op2_rdy_w, op2: d_op2_w};

    // Oldest valid entry whose registered operands are both ready
    always_comb begin
        found_c   = 1'b0;
        sel_idx_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!found_c && (CNT_W'(i) < count_q) && ent_q[i].op1_rdy && ent_q[i].op2_rdy) begin
                found_c   = 1'b1;
                sel_idx_c = IDX_W'(i);
            end
        end
    end

    assign rs_stall          = (count_q == CNT_W'(DEPTH));
    assign exers_mcalu_issue = found_c;
    assign exers_mcalu_op    = ent_q[sel_idx_c].op;
    assign exers_robid       = ent_q[sel_idx_c].robid;
    assign exers_rd          = ent_q[sel_idx_c].rd;
    assign exers_op1         = ent_q[sel_idx_c].op1;
    assign exers_op2         = ent_q[sel_idx_c].op2;

    // Next queue contents: wakeup, compaction above the issued slot, then dispatch at the tail
    always_comb begin
        issue_acc_c = exers_mcalu_issue & ~mcalu_stall;
        disp_acc_c  = disp_valid & ~rs_stall & ~rob_flush;
        wr_idx_c    = count_q - CNT_W'(issue_acc_c);
        count_d     = count_q - CNT_W'(issue_acc_c) + CNT_W'(disp_acc_c);
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = woke_c[i];
            if (issue_acc_c && (IDX_W'(i) >= sel_idx_c)) begin
                ent_d[i] = shift_c[i];
            end
            if (disp_acc_c && (CNT_W'(i) == wr_idx_c)) begin
                ent_d[i] = disp_c;
            end
        end
        if (rob_flush) begin
            count_d = '0;
        end
    end

    // Occupancy; validity of a slot is implied by its index being below count
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry payloads carry no reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_q[i] <= ent_d[i];
        end
    end

endmodule

// File: tb/tb_mcalu_rs.sv
// Directed self-checking bench for mcalu_rs (DEPTH=4).
module tb_mcalu_rs;
    import mcalu_rs_pkg::*;

    logic               clk;
    logic               rst;
    logic               disp_valid;
    logic [OP_W-1:0]    disp_op;
    logic [ROBID_W-1:0] disp_robid;
    logic [RD_W-1:0]    disp_rd;
    logic               disp_op1_rdy;
    logic               disp_op2_rdy;
    logic [DATA_W-1:0]  disp_op1;
    logic [DATA_W-1:0]  disp_op2;
    logic               rs_stall;
    logic               wb_valid;
    logic [ROBID_W-1:0] wb_robid;
    logic [DATA_W-1:0]  wb_result;
    logic               exers_mcalu_issue;
    logic [OP_W-1:0]    exers_mcalu_op;
    logic [ROBID_W-1:0] exers_robid;
    logic [RD_W-1:0]    exers_rd;
    logic [DATA_W-1:0]  exers_op1;
    logic [DATA_W-1:0]  exers_op2;
    logic               mcalu_stall;
    logic               rob_flush;

    int n_cmp;
    int n_err;

    mcalu_rs #(.DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .disp_valid        (disp_valid),
        .disp_op           (disp_op),
        .disp_robid        (disp_robid),
        .disp_rd           (disp_rd),
        .disp_op1_rdy      (disp_op1_rdy),
        .disp_op2_rdy      (disp_op2_rdy),
        .disp_op1          (disp_op1),
        .disp_op2          (disp_op2),
        .rs_stall          (rs_stall),
        .wb_valid          (wb_valid),
        .wb_robid          (wb_robid),
        .wb_result         (wb_result),
        .exers_mcalu_issue (exers_mcalu_issue),
        .exers_mcalu_op    (exers_mcalu_op),
        .exers_robid       (exers_robid),
        .exers_rd          (exers_rd),
        .exers_op1         (exers_op1),
        .exers_op2         (exers_op2),
        .mcalu_stall       (mcalu_stall),
        .rob_flush         (rob_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_disp(input logic [ROBID_W-1:0] robid, input logic [OP_W-1:0] op,
                            input logic r1, input logic [DATA_W-1:0] o1,
                            input logic r2, input logic [DATA_W-1:0] o2);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_robid   = robid;
        disp_rd      = robid[RD_W-1:0];
        disp_op1_rdy = r1;
        disp_op1     = o1;
        disp_op2_rdy = r2;
        disp_op2     = o2;
    endtask

    task automatic clr_disp();
        disp_valid = 1'b0;
    endtask

    task automatic set_wb(input logic [ROBID_W-1:0] tag, input logic [DATA_W-1:0] res);
        wb_valid  = 1'b1;
        wb_robid  = tag;
        wb_result = res;
    endtask

    task automatic clr_wb();
        wb_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step();
        step();
        n_cmp++; if (rs_stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", rs_stall); end
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL reset_issue: got %b want 0", exers_mcalu_issue); end
        rst = 1'b1;
        step();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL idle_issue: got %b want 0", exers_mcalu_issue); end
    endtask

    task automatic test_basic();
        set_disp(7'h10, MCALU_ADD, 1'b1, 32'd5, 1'b1, 32'd7);
        step();
        clr_disp();
        n_cmp++; if (exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL basic_issue: got %b want 1", exers_mcalu_issue); end
        n_cmp++; if (exers_mcalu_op !== MCALU_ADD) begin n_err++; $display("FAIL basic_op: got %h want %h", exers_mcalu_op, MCALU_ADD); end
        n_cmp++; if (exers_robid !== 7'h10) begin n_err++; $display("FAIL basic_robid: got %h want 10", exers_robid); end
        n_cmp++; if (exers_rd !== 6'h10) begin n_err++; $display("FAIL basic_rd: got %h want 10", exers_rd); end
        n_cmp++; if (exers_op1 !== 32'd5) begin n_err++; $display("FAIL basic_op1: got %0d want 5", exers_op1); end
        n_cmp++; if (exers_op2 !== 32'd7) begin n_err++; $display("FAIL basic_op2: got %0d want 7", exers_op2); end
        step();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL basic_drained: got %b want 0", exers_mcalu_issue); end
        n_cmp++; if (rs_stall !== 1'b0) begin n_err++; $display("FAIL basic_stall: got %b want 0", rs_stall); end
    endtask

    task automatic test_wakeup();
        set_disp(7'h20, MCALU_MUL, 1'b1, 32'd3, 1'b0, 32'h12);
        step();
        clr_disp();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL wake_pending1: got %b want 0", exers_mcalu_issue); end
        step();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL wake_pending2: got %b want 0", exers_mcalu_issue); end
        set_wb(7'h12, 32'hDEADBEEF);
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL wake_same_cycle: got %b want 0", exers_mcalu_issue); end
        step();
        clr_wb();
        n_cmp++; if (exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL wake_issue: got %b want 1", exers_mcalu_issue); end
        n_cmp++; if (exers_robid !== 7'h20) begin n_err++; $display("FAIL wake_robid: got %h want 20", exers_robid); end
        n_cmp++; if (exers_op2 !== 32'hDEADBEEF) begin n_err++; $display("FAIL wake_op2: got %h want deadbeef", exers_op2); end
        n_cmp++; if (exers_op1 !== 32'd3) begin n_err++; $display("FAIL wake_op1: got %h want 3", exers_op1); end
        step();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL wake_drained: got %b want 0", exers_mcalu_issue); end
    endtask

    task automatic test_bypass();
        // Matching broadcast in the dispatch cycle
        set_disp(7'h30, MCALU_SUB, 1'b0, 32'h33, 1'b1, 32'd9);
        set_wb(7'h33, 32'h1234);
        step();
        clr_disp();
        clr_wb();
        n_cmp++; if (exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL bypass_issue: got %b want 1", exers_mcalu_issue); end
        n_cmp++; if (exers_op1 !== 32'h1234) begin n_err++; $display("FAIL bypass_op1: got %h want 1234", exers_op1); end
        step();
        // Non-matching tag must leave the operand pending
        set_disp(7'h31, MCALU_SUB, 1'b0, 32'h33, 1'b1, 32'd9);
        set_wb(7'h34, 32'h5678);
        step();
        clr_disp();
        clr_wb();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL bypass_nomatch: got %b want 0", exers_mcalu_issue); end
        set_wb(7'h33, 32'h9abc);
        step();
        clr_wb();
        n_cmp++; if (exers_robid !== 7'h31 || exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL bypass_late_wake: got %b/%h want 1/31", exers_mcalu_issue, exers_robid); end
        n_cmp++; if (exers_op1 !== 32'h9abc) begin n_err++; $display("FAIL bypass_late_op1: got %h want 9abc", exers_op1); end
        step();
    endtask

    task automatic test_full();
        logic [ROBID_W-1:0] exp_id;
        mcalu_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_disp(ROBID_W'(8'h40 + i), MCALU_DIV, 1'b1, 32'(i), 1'b1, 32'(i + 100));
            step();
        end
        // Dispatcher misbehaves: request while full
        set_disp(7'h7f, MCALU_DIV, 1'b1, 32'd0, 1'b1, 32'd0);
        n_cmp++; if (rs_stall !== 1'b1) begin n_err++; $display("FAIL full_stall: got %b want 1", rs_stall); end
        n_cmp++; if (exers_robid !== 7'h40 || exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL full_head: got %b/%h want 1/40", exers_mcalu_issue, exers_robid); end
        step();
        clr_disp();
        n_cmp++; if (exers_robid !== 7'h40 || rs_stall !== 1'b1) begin n_err++; $display("FAIL full_hold: got %h/%b want 40/1", exers_robid, rs_stall); end
        mcalu_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            exp_id = ROBID_W'(8'h41 + i);
            if (i < 3) begin
                n_cmp++; if (exers_robid !== exp_id || exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL drain_order_%0d: got %b/%h want 1/%h", i, exers_mcalu_issue, exers_robid, exp_id); end
                n_cmp++; if (rs_stall !== 1'b0) begin n_err++; $display("FAIL drain_stall_%0d: got %b want 0", i, rs_stall); end
            end else begin
                n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", exers_mcalu_issue); end
            end
        end
        // Full boundary: dispatch together with an accepted issue is not taken
        mcalu_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_disp(ROBID_W'(8'h50 + i), MCALU_REM, 1'b1, 32'd1, 1'b1, 32'd2);
            step();
        end
        set_disp(7'h5f, MCALU_REM, 1'b1, 32'd1, 1'b1, 32'd2);
        mcalu_stall = 1'b0;
        step();
        clr_disp();
        n_cmp++; if (rs_stall !== 1'b0) begin n_err++; $display("FAIL boundary_stall: got %b want 0", rs_stall); end
        n_cmp++; if (exers_robid !== 7'h51) begin n_err++; $display("FAIL boundary_next: got %h want 51", exers_robid); end
        step();
        step();
        n_cmp++; if (exers_robid !== 7'h53 || exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL boundary_last: got %b/%h want 1/53", exers_mcalu_issue, exers_robid); end
        step();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL boundary_dropped: got %b want 0", exers_mcalu_issue); end
    endtask

    task automatic test_order();
        mcalu_stall = 1'b1;
        set_disp(7'h60, MCALU_ADD, 1'b0, 32'h05, 1'b1, 32'd1);
        step();
        set_disp(7'h61, MCALU_ADD, 1'b1, 32'd2, 1'b1, 32'd3);
        step();
        set_disp(7'h62, MCALU_ADD, 1'b1, 32'd4, 1'b0, 32'h06);
        step();
        clr_disp();
        n_cmp++; if (exers_robid !== 7'h61 || exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL order_first: got %b/%h want 1/61", exers_mcalu_issue, exers_robid); end
        // C shifts from slot 2 to slot 1 while being woken
        mcalu_stall = 1'b0;
        set_wb(7'h06, 32'h66);
        step();
        set_wb(7'h05, 32'h55);
        n_cmp++; if (exers_robid !== 7'h62 || exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL order_shift_wake: got %b/%h want 1/62", exers_mcalu_issue, exers_robid); end
        n_cmp++; if (exers_op2 !== 32'h66) begin n_err++; $display("FAIL order_shift_op2: got %h want 66", exers_op2); end
        step();
        clr_wb();
        n_cmp++; if (exers_robid !== 7'h60 || exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL order_oldest: got %b/%h want 1/60", exers_mcalu_issue, exers_robid); end
        n_cmp++; if (exers_op1 !== 32'h55) begin n_err++; $display("FAIL order_oldest_op1: got %h want 55", exers_op1); end
        step();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL order_empty: got %b want 0", exers_mcalu_issue); end
    endtask

    task automatic test_flush();
        mcalu_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_disp(ROBID_W'(8'h70 + i), MCALU_SLL, 1'b1, 32'd1, 1'b1, 32'd1);
            step();
        end
        set_disp(7'h7a, MCALU_SLL, 1'b1, 32'd1, 1'b1, 32'd1);
        rob_flush = 1'b1;
        step();
        rob_flush = 1'b0;
        clr_disp();
        mcalu_stall = 1'b0;
        n_cmp++; if (exers_mcalu_issue !== 1'b0 || rs_stall !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b/%b want 0/0", exers_mcalu_issue, rs_stall); end
        step();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL flush_disp_dropped: got %b want 0", exers_mcalu_issue); end
        // Reset mid-stream behaves the same way
        mcalu_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_disp(ROBID_W'(8'h78 + i), MCALU_SRL, 1'b1, 32'd1, 1'b1, 32'd1);
            step();
        end
        set_disp(7'h7b, MCALU_SRL, 1'b1, 32'd1, 1'b1, 32'd1);
        rst = 1'b0;
        step();
        rst = 1'b1;
        clr_disp();
        mcalu_stall = 1'b0;
        n_cmp++; if (exers_mcalu_issue !== 1'b0 || rs_stall !== 1'b0) begin n_err++; $display("FAIL rst_mid_empty: got %b/%b want 0/0", exers_mcalu_issue, rs_stall); end
        step();
        n_cmp++; if (exers_mcalu_issue !== 1'b0) begin n_err++; $display("FAIL rst_mid_dropped: got %b want 0", exers_mcalu_issue); end
        // Still operational afterwards
        set_disp(7'h0c, MCALU_SRA, 1'b1, 32'hc0, 1'b1, 32'h0c);
        step();
        clr_disp();
        n_cmp++; if (exers_robid !== 7'h0c || exers_mcalu_issue !== 1'b1) begin n_err++; $display("FAIL post_rst_issue: got %b/%h want 1/0c", exers_mcalu_issue, exers_robid); end
        step();
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        rst          = 1'b0;
        disp_valid   = 1'b0;
        disp_op      = '0;
        disp_robid   = '0;
        disp_rd      = '0;
        disp_op1_rdy = 1'b0;
        disp_op2_rdy = 1'b0;
        disp_op1     = '0;
        disp_op2     = '0;
        wb_valid     = 1'b0;
        wb_robid     = '0;
        wb_result    = '0;
        mcalu_stall  = 1'b0;
        rob_flush    = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_wakeup();
        test_bypass();
        test_full();
        test_order();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mcalu_rs.md
# mcalu_rs

Reservation station directly upstream of the multi-cycle ALU (mcalu). It accepts dispatched MCALU ops with source operands that are either ready values or pending ROB tags. It captures pending operands from the writeback broadcast bus. Each cycle it issues the oldest fully-ready entry to mcalu, honouring mcalu's stall.

## Interface
Parameters:
- DEPTH, 4: number of entries (2..8).

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst  in  1  reset, synchronous, active-low (0 = reset).
- disp_valid  in  1  dispatch request this cycle.
- disp_op  in  5  mcalu op code, passed through unchanged.
- disp_robid  in  7  ROB id of the instruction.
- disp_rd  in  6  destination register.
- disp_op1_rdy, disp_op2_rdy  in  1 each  operand holds a value (1) or a producer tag (0).
- disp_op1, disp_op2  in  32 each  value if ready, else producer robid in [6:0].
- rs_stall  out  1  RS full; dispatcher must hold the request.
- wb_valid  in  1  writeback broadcast valid.
- wb_robid  in  7  producer tag being broadcast.
- wb_result  in  32  broadcast value.
- exers_mcalu_issue  out  1  issue valid to mcalu.
- exers_mcalu_op  out  5  op of the issued entry.
- exers_robid  out  7  robid of the issued entry.
- exers_rd  out  6  rd of the issued entry.
- exers_op1  out  32  op1 of the issued entry.
- exers_op2  out  32  op2 of the issued entry.
- mcalu_stall  in  1  mcalu cannot accept this cycle.
- rob_flush  in  1  discard all entries.

## Operation
- Storage is a compacting age-ordered queue. Entry 0 is the oldest. `count` ranges 0..DEPTH.
- Each entry holds: op, robid, rd, and per operand a rdy bit plus 32 bits of value/tag.
- Dispatch is accepted when disp_valid & ~rs_stall & ~rob_flush & rst.
  - The new entry is written at slot `count`, or at slot `count-1` if an issue is accepted in the same cycle.
- rs_stall = (count == DEPTH). It depends on count only; a same-cycle issue does not free a slot for dispatch.
- Wakeup: for every valid entry operand with rdy=0 and value[6:0]==wb_robid while wb_valid, the next state is rdy=1 and value=wb_result.
  - Wakeup applies to the incoming dispatch operands in the same cycle (bypass), so no broadcast is lost.
- Select: issue candidate = lowest-index valid entry with both rdy bits set. Readiness is registered only; a wakeup this cycle makes the entry eligible next cycle.
- exers_mcalu_issue = candidate exists. It is combinational from registered state and is independent of mcalu_stall.
  - exers_* carry the candidate's fields; they are don't-care when issue=0.
- Issue is accepted when exers_mcalu_issue & ~mcalu_stall. On acceptance the entry is removed and all higher entries shift down by one, keeping their age order.
  - A wakeup on a shifting entry lands in its new slot.
- rob_flush: at the next edge all entries become invalid and count=0. A dispatch in the same cycle is dropped. Issue outputs in the flush cycle are ignored by mcalu.
- Reset (rst=0 at an edge): count=0 and all entries invalid, overriding dispatch, wakeup and flush. Entry payloads need not be reset.

## Timing
- Reset values: rs_stall=0, exers_mcalu_issue=0.
- Latency from dispatch with both operands ready to exers_mcalu_issue=1: 1 cycle (the entry is visible after the edge).
- Latency from wb broadcast to issue of a woken entry: 1 cycle.
- Back-to-back issue on consecutive cycles is allowed when mcalu_stall=0.
- Under mcalu_stall=1 the candidate and its outputs hold stable, unless an older entry becomes ready. Mcalu only samples the outputs on a non-stalled cycle, so this is legal.
- Full boundary: with count==DEPTH, dispatch plus simultaneous issue leaves count at DEPTH-1 and the dispatch is not taken.
- Empty boundary: count==0 gives issue=0.
- count never wraps or underflows. Dispatch while full must be ignored even if the dispatcher misbehaves.

## Structure
- Shared package holds:
  - the mcalu op-code localparams (e.g. the ADD/SUB, shift, MUL, DIV/REM encodings) used by decode, the RS and mcalu;
  - the robid width (7), rd width (6) and data width (32);
  - an entry struct/typedef of op, robid, rd, op1_rdy, op1, op2_rdy, op2.
- One natural sub-module: `rs_operand_wakeup`, a per-operand tag compare plus capture mux, instantiated 2×DEPTH+2 times (entries plus the dispatch bypass).

## Test plan
- Dispatch op=ADD, op1=5, op2=7, both ready, mcalu_stall=0 → next cycle issue=1 with op1=5, op2=7, robid echoed; next cycle after that issue=0, count=0.
- Dispatch with op2 pending on tag 0x12; wb_valid, robid=0x12, result=0xDEADBEEF two cycles later → issue exactly one cycle after the broadcast with op2=0xDEADBEEF.
- Dispatch and broadcast of its pending tag in the same cycle → entry is stored ready and issues next cycle (bypass).
- Fill 4 entries, all ready, holding mcalu_stall=1 → rs_stall=1, issue holds the robid of entry 0. Release the stall → issues appear in dispatch order on 4 consecutive cycles, and rs_stall drops after the first issue.
- Entries A (older, pending) and B (ready); wake A → B issues first, then A. Order is preserved across the compaction.
- 3 entries valid, assert rob_flush together with a dispatch → next cycle count=0, issue=0, rs_stall=0. Assert rst=0 mid-stream → same result.
